inst_decode_queue: RTL and testbench
====================================

// Module: inst_decode_queue
// PURPOSE
//  Parametrised successor to the combinational field splitter: an IF->ID instruction queue.
//  Buffers fetched instructions with their PC in a DEPTH-entry FIFO and decodes the head entry.
//  Decoded outputs: fields, extended immediates and jump target.
//  Sits between fetch and decode; decouples fetch from ID stalls and flushes on taken J/BEQ redirect.
// PARAMETERS
//  DEPTH    2   queue entries; power of 2, >=2
//  PC_W     32  PC / jump-target width; >=28
//  IMM_W    32  width of extended immediates; >=16
//  CNT_W    $clog2(DEPTH)+1  occupancy counter width (derived, do not override)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       synchronous reset, active-high
//  flush        in   1       synchronous discard of all queued entries (branch/jump redirect)
//  in_valid     in   1       fetch offers in_inst/in_pc this cycle
//  in_ready     out  1       queue accepts an entry this cycle
//  in_inst      in   32      fetched instruction word
//  in_pc        in   PC_W    PC of in_inst
//  out_ready    in   1       ID consumes head entry this cycle (0 = ID stall)
//  out_valid    out  1       head entry valid
//  out_pc       out  PC_W    PC of head entry
//  opcode       out  6       head[31:26]
//  rs,rt,rd     out  5 each  head[25:21], head[20:16], head[15:11]
//  shamt        out  5       head[10:6]
//  funct        out  6       head[5:0]
//  imm          out  16      head[15:0]
//  imm_sext     out  IMM_W   sign-extended imm
//  imm_zext     out  IMM_W   zero-extended imm
//  instr_index  out  26      head[25:0]
//  jump_target  out  PC_W    {pc4[PC_W-1:28], instr_index, 2'b00}, pc4 = out_pc+4 mod 2^PC_W
//  count        out  CNT_W   current occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0; thereafter out_valid=0, in_ready=1.
//    All decoded outputs and out_pc read 0. Storage contents need not be cleared.
//  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH), registered-state only. No combinational path from out_ready.
//  - out_valid = (count != 0). No bypass: an entry pushed at edge N appears at out_* after edge N (1-cycle latency).
//  - Push writes {in_inst,in_pc} at wr_ptr, wr_ptr+1. Pop advances rd_ptr. Pointers wrap modulo DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop.
//  - Full (count=DEPTH): in_ready=0; a simultaneous pop does NOT enable a push that cycle.
//  - Empty: pop impossible. out_ready is ignored.
//  - Decoded outputs are combinational from the head entry (registered storage).
//    When out_valid=0, all decoded outputs and out_pc are forced to 0 (bubble = NOP).
//  - flush=1 at edge: count=0, rd_ptr=wr_ptr=0. A same-cycle in_valid is dropped.
//    A same-cycle pop is irrelevant (queue empty next cycle). rst has priority over flush.
//  - Width rules: pc4 wraps modulo 2^PC_W. jump_target upper bits come from pc4, not out_pc.
//    imm_sext replicates imm[15] into bits IMM_W-1:16.
//  - FIFO order strictly preserved; no entry duplicated or lost except by flush/rst.
// TESTING
//  T1 reset: rst=1 two cycles -> count=0, out_valid=0, in_ready=1, opcode..jump_target=0.
//  T2 lw decode: push 0x8C2A0004 @pc 0x00400000 -> next cycle out_valid=1, opcode=0x23, rs=1, rt=10, imm=0x0004, imm_sext=0x00000004.
//  T3 sign ext + jump: push 0x2021FFFF -> imm_sext=0xFFFFFFFF, imm_zext=0x0000FFFF; push 0x08100008 @pc 0x00400010 -> instr_index=0x0100008, jump_target=0x00400020.
//  T4 full/stall: out_ready=0, push DEPTH(=2) entries -> count=2, in_ready=0; third in_valid held; in_ready=1 only after pop; order A,B,C out.
//  T5 simultaneous push/pop at count=1 -> count stays 1, head advances to next entry each cycle, no loss.
//  T6 flush: count=2 with in_valid=1 and flush=1 -> next cycle count=0, out_valid=0, pushed word absent; next push appears normally.

Source files
------------

// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - IF->ID instruction queue with head-entry field decode
// Buffers {instruction, PC} pairs in a DEPTH-entry FIFO and decodes the oldest entry.

module inst_decode_queue #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int IMM_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [IMM_W-1:0]  imm_sext,
    output logic [IMM_W-1:0]  imm_zext,
    output logic [25:0]       instr_index,
    output logic [PC_W-1:0]   jump_target,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    // Keeps only the region bits of pc4; the low 28 come from instr_index.
    localparam logic [PC_W-1:0] REGION_MASK = ~PC_W'(28'hFFF_FFFF);

    logic [31:0]      inst_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic [31:0]      head_inst;
    logic [PC_W-1:0]  head_pc;
    logic [PC_W-1:0]  pc4;

    // Flow control depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // An empty queue presents an all-zero bubble so ID sees a NOP.
    always_comb begin
        head_inst = '0;
        head_pc   = '0;
        if (out_valid) begin
            head_inst = inst_mem[rd_ptr];
            head_pc   = pc_mem[rd_ptr];
        end
    end

    assign pc4         = head_pc + PC_W'(4);
    assign out_pc      = head_pc;
    assign opcode      = head_inst[31:26];
    assign rs          = head_inst[25:21];
    assign rt          = head_inst[20:16];
    assign rd          = head_inst[15:11];
    assign shamt       = head_inst[10:6];
    assign funct       = head_inst[5:0];
    assign imm         = head_inst[15:0];
    assign instr_index = head_inst[25:0];
    assign imm_sext    = IMM_W'(signed'(head_inst[15:0]));
    assign imm_zext    = IMM_W'(head_inst[15:0]);

    always_comb begin
        jump_target = '0;
        if (out_valid) begin
            jump_target = (pc4 & REGION_MASK) | PC_W'({head_inst[25:0], 2'b00});
        end
    end

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb/tb_inst_decode_queue.sv - scoreboard bench for inst_decode_queue
// Stimulus pushes accepted vector indices; a monitor pops and compares on every DUT pop.

module tb_inst_decode_queue;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int IMM_W = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] sext;
        logic [31:0] zext;
        logic [25:0] index;
        logic [31:0] jt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [IMM_W-1:0]  imm_sext;
    logic [IMM_W-1:0]  imm_zext;
    logic [25:0]       instr_index;
    logic [PC_W-1:0]   jump_target;
    logic [CNT_W-1:0]  count;

    vec_t vecs [8];
    int   sb [$];
    int   cur_idx;
    int   mcount;
    int   tests;
    int   fails;
    bit   mon_en;

    inst_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .imm_sext(imm_sext), .imm_zext(imm_zext),
        .instr_index(instr_index), .jump_target(jump_target), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        int idx;
        if (!mon_en) return;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                idx = sb.pop_front();
                check("out_pc",      out_pc,      vecs[idx].pc);
                check("opcode",      32'(opcode), 32'(vecs[idx].opcode));
                check("rs",          32'(rs),     32'(vecs[idx].rs));
                check("rt",          32'(rt),     32'(vecs[idx].rt));
                check("rd",          32'(rd),     32'(vecs[idx].rd));
                check("shamt",       32'(shamt),  32'(vecs[idx].shamt));
                check("funct",       32'(funct),  32'(vecs[idx].funct));
                check("imm",         32'(imm),    32'(vecs[idx].inst[15:0]));
                check("imm_sext",    imm_sext,    vecs[idx].sext);
                check("imm_zext",    imm_zext,    vecs[idx].zext);
                check("instr_index", 32'(instr_index), 32'(vecs[idx].index));
                check("jump_target", jump_target, vecs[idx].jt);
            end
        end
        if (!out_valid) begin
            check("bubble_zero", 32'(|{out_pc, opcode, rs, rt, rd, shamt, funct, imm,
                                       imm_sext, imm_zext, instr_index, jump_target}), 32'd0);
        end
    endtask

    task automatic drive(input int idx, input logic v);
        cur_idx  = idx;
        in_valid = v;
        in_inst  = vecs[idx].inst;
        in_pc    = vecs[idx].pc;
    endtask

    // One clock edge with the bench's own occupancy model, then status checks.
    task automatic step();
        bit do_push;
        bit do_pop;
        do_push = in_valid && (mcount < DEPTH) && !flush;
        do_pop  = (mcount != 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            mcount = 0;
            sb.delete();
        end else begin
            if (do_push) sb.push_back(cur_idx);
            mcount = mcount + int'(do_push) - int'(do_pop);
        end
        #1;
        check("count",     32'(count),     32'(mcount));
        check("in_ready",  32'(in_ready),  32'(mcount < DEPTH));
        check("out_valid", 32'(out_valid), 32'(mcount != 0));
    endtask

    initial begin
        vecs[0] = '{32'h8C2A0004, 32'h00400000, 6'h23, 5'd1,  5'd10, 5'd0,  5'd0,  6'h04,
                    32'h00000004, 32'h00000004, 26'h02A0004, 32'h00A80010};
        vecs[1] = '{32'h2021FFFF, 32'h00400004, 6'h08, 5'd1,  5'd1,  5'd31, 5'd31, 6'h3F,
                    32'hFFFFFFFF, 32'h0000FFFF, 26'h021FFFF, 32'h0087FFFC};
        vecs[2] = '{32'h08100008, 32'h00400010, 6'h02, 5'd0,  5'd16, 5'd0,  5'd0,  6'h08,
                    32'h00000008, 32'h00000008, 26'h0100008, 32'h00400020};
        vecs[3] = '{32'h0BFFFFFF, 32'hFFFFFFFC, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,
                    32'hFFFFFFFF, 32'h0000FFFF, 26'h3FFFFFF, 32'h0FFFFFFC};
        vecs[4] = '{32'h0C000001, 32'h1FFFFFF8, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01,
                    32'h00000001, 32'h00000001, 26'h0000001, 32'h10000004};
        vecs[5] = '{32'h00000000, 32'h2FFFFFFC, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00,
                    32'h00000000, 32'h00000000, 26'h0000000, 32'h30000000};
        vecs[6] = '{32'h3C018000, 32'h00400020, 6'h0F, 5'd0,  5'd1,  5'd16, 5'd0,  6'h00,
                    32'hFFFF8000, 32'h00008000, 26'h0018000, 32'h00060000};
        vecs[7] = '{32'hDEADBEEF, 32'h0000BAD0, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00,
                    32'h00000000, 32'h00000000, 26'h0000000, 32'h00000000};

        tests = 0; fails = 0; mcount = 0; mon_en = 1'b0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, 1'b0);

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset: two cycles, outputs idle and decoded bubble.
        step();
        mon_en = 1'b1;
        step();
        check("reset_jump_target", jump_target, 32'h0);
        check("reset_opcode", 32'(opcode), 32'h0);
        rst = 1'b0;

        // lw decode: visible one cycle after the push, held while ID stalls.
        drive(0, 1'b1);
        step();
        drive(0, 1'b0);
        check("lw_opcode", 32'(opcode), 32'h23);
        check("lw_imm_sext", imm_sext, 32'h00000004);
        step();
        out_ready = 1'b1;
        step();

        // Streaming: push and pop every cycle, occupancy stays at 1.
        for (int i = 1; i <= 6; i++) begin
            drive(i, 1'b1);
            step();
            if (i > 1) check("stream_count", 32'(count), 32'd1);
        end
        drive(0, 1'b0);
        for (int i = 0; i < 4 && mcount != 0; i++) step();
        check("stream_drained", 32'(count), 32'd0);

        // Full: two entries with ID stalled, third held off until a pop.
        out_ready = 1'b0;
        drive(0, 1'b1); step();
        drive(1, 1'b1); step();
        drive(2, 1'b1); step();
        check("full_count", 32'(count), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        step();
        check("pop_no_push_count", 32'(count), 32'd1);
        step();
        drive(2, 1'b0);
        for (int i = 0; i < 4 && mcount != 0; i++) step();
        check("full_drained", 32'(count), 32'd0);

        // Flush with a same-cycle push: queue empties, dropped word never appears.
        out_ready = 1'b0;
        drive(6, 1'b1); step();
        drive(0, 1'b1); step();
        drive(7, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(7, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        step();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drive(4, 1'b1); step();
        drive(4, 1'b0);
        check("post_flush_jt", jump_target, 32'h10000004);
        out_ready = 1'b1;
        step();

        // Reset wins over flush and a pending push.
        out_ready = 1'b0;
        drive(3, 1'b1); step();
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        drive(3, 1'b0);
        step();
        check("rst_over_flush", 32'(count), 32'd0);

        // Pointer wrap after reset, then drain.
        out_ready = 1'b1;
        drive(5, 1'b1); step();
        drive(3, 1'b1); step();
        drive(3, 1'b0);
        for (int i = 0; i < 4 && mcount != 0; i++) step();
        check("final_count", 32'(count), 32'd0);
        check("sb_leftover", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
